// File: rtl/mem_dumper.sv
// mem_dumper: streams a block of external memory out over a UART.
//
// On an accepted start, `count` bytes are read one at a time from
// `base_adr` upward and sent 8N1, LSB first, each bit CLK_DIV clocks long.
// Each byte is read, then sent only once `hold` is low, then the next read
// follows straight after the stop bit.
//
// Ports:
//   clk       in   clock, all state on the rising edge
//   reset     in   asynchronous active-high reset
//   start     in   one-cycle dump request (accepted only while idle)
//   base_adr  in   [20:0] first byte address, sampled on accepted start
//   count     in   [20:0] byte count, sampled on accepted start
//   adr       out  [20:0] memory address (changes only at the end of a read)
//   read      out  memory read strobe
//   data      in   [7:0] memory read data
//   tx        out  UART line, idle high
//   hold      in   flow control, high = receiver not ready
//   busy      out  high from accepted start until the dump ends
//   done      out  one-cycle pulse when the dump ends
module mem_dumper #(
    parameter int CLK_DIV = 104,
    parameter int RD_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] base_adr,
    input  logic [20:0] count,
    output logic [20:0] adr,
    output logic        read,
    input  logic [7:0]  data,
    output logic        tx,
    input  logic        hold,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_WAIT_TX   = 3'd2;
    localparam logic [2:0] S_START_BIT = 3'd3;
    localparam logic [2:0] S_DATA_BITS = 3'd4;
    localparam logic [2:0] S_STOP_BIT  = 3'd5;

    localparam int BT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(CLK_DIV - 1);
    localparam logic [RW_W-1:0] RW_LAST = RW_W'(RD_WAIT);

    logic [2:0]      state_q,   state_d;
    logic [20:0]     adr_q,     adr_d;
    logic [20:0]     rem_q,     rem_d;
    logic [7:0]      shift_q,   shift_d;
    logic [BT_W-1:0] bit_tmr_q, bit_tmr_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [RW_W-1:0] rd_tmr_q,  rd_tmr_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    logic bit_end;
    assign bit_end = (bit_tmr_q == BT_LAST);

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        rem_d     = rem_q;
        shift_d   = shift_q;
        bit_tmr_d = bit_tmr_q;
        bit_idx_d = bit_idx_q;
        rd_tmr_d  = rd_tmr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == 21'd0) begin
                        // Empty dump: finish immediately without going busy.
                        done_d = 1'b1;
                    end else begin
                        adr_d    = base_adr;
                        rem_d    = count;
                        rd_tmr_d = '0;
                        busy_d   = 1'b1;
                        state_d  = S_READ;
                    end
                end
            end
            S_READ: begin
                if (rd_tmr_q == RW_LAST) begin
                    // Last strobe cycle: capture the byte, then advance.
                    // The 21-bit add wraps 0x1FFFFF to 0 on its own.
                    shift_d  = data;
                    adr_d    = adr_q + 21'd1;
                    rem_d    = rem_q - 21'd1;
                    rd_tmr_d = '0;
                    state_d  = S_WAIT_TX;
                end else begin
                    rd_tmr_d = rd_tmr_q + 1'b1;
                end
            end
            S_WAIT_TX: begin
                if (!hold) begin
                    bit_tmr_d = '0;
                    state_d   = S_START_BIT;
                end
            end
            S_START_BIT: begin
                if (bit_end) begin
                    bit_tmr_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA_BITS;
                end else begin
                    bit_tmr_d = bit_tmr_q + 1'b1;
                end
            end
            S_DATA_BITS: begin
                if (bit_end) begin
                    bit_tmr_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_tmr_d = bit_tmr_q + 1'b1;
                end
            end
            S_STOP_BIT: begin
                if (bit_end) begin
                    bit_tmr_d = '0;
                    if (rem_q != 21'd0) begin
                        rd_tmr_d = '0;
                        state_d  = S_READ;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_tmr_d = bit_tmr_q + 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            bit_tmr_q <= '0;
            bit_idx_q <= '0;
            rd_tmr_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            bit_tmr_q <= bit_tmr_d;
            bit_idx_q <= bit_idx_d;
            rd_tmr_q  <= rd_tmr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Outputs decode registered state only, so reset forces them at once.
    always_comb begin
        tx = 1'b1;
        if (state_q == S_START_BIT) begin
            tx = 1'b0;
        end else if (state_q == S_DATA_BITS) begin
            tx = shift_q[0];
        end
    end

    assign read = (state_q == S_READ);
    assign adr  = adr_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_mem_dumper.sv
// Directed bench for mem_dumper: checks UART frames cycle by cycle,
// read bursts, done/busy timing, hold flow control, ignored restarts,
// address wrap, empty dumps and mid-frame reset.
`timescale 1ns/1ps
module tb_mem_dumper;
    localparam int CLK_DIV = 104;
    localparam int RD_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [20:0] base_adr = '0;
    logic [20:0] count = '0;
    logic [20:0] adr;
    logic        read;
    logic [7:0]  data;
    logic        tx;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    // Read monitor state.
    logic [20:0] rd_adr_log[$];
    int          rd_len_log[$];
    int          rd_adr_moved = 0;
    int          done_cnt = 0;
    int          rd_cyc = 0;
    int          cur_len = 0;
    logic        read_prev = 1'b0;
    logic [20:0] first_adr = '0;

    always #5 clk = ~clk;

    mem_dumper #(.CLK_DIV(CLK_DIV), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .reset(reset), .start(start), .base_adr(base_adr),
        .count(count), .adr(adr), .read(read), .data(data), .tx(tx),
        .hold(hold), .busy(busy), .done(done)
    );

    function automatic logic [7:0] mem_byte(input logic [20:0] a);
        case (a)
            21'h00100: return 8'hA5;
            21'h00101: return 8'h3C;
            default:   return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
        endcase
    endfunction

    // Memory returns the true byte only on the last strobe cycle, so a
    // sample taken at any other time shows up as a corrupted frame.
    assign data = (read && rd_cyc == RD_WAIT) ? mem_byte(adr) : ~mem_byte(adr);

    always @(posedge clk) rd_cyc <= read ? rd_cyc + 1 : 0;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (read && !read_prev) begin
            rd_adr_log.push_back(adr);
            first_adr <= adr;
            cur_len   <= 1;
        end else if (read) begin
            cur_len <= cur_len + 1;
            if (adr != first_adr) rd_adr_moved <= rd_adr_moved + 1;
        end
        if (!read && read_prev) rd_len_log.push_back(cur_len);
        read_prev <= read;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [20:0] b, input logic [20:0] n);
        base_adr = b;
        count    = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Waits for the start bit, checks its latency, then checks every cycle
    // of all ten bit periods. Ends just after the edge that ends the stop bit.
    task automatic rx_frame(input string tag, input logic [7:0] exp_b, input int exp_wait);
        logic [9:0] bits;
        int w;
        int bad;
        bits = {1'b1, exp_b, 1'b0};
        w = 0;
        while (tx !== 1'b0 && w < 5000) begin
            tick();
            w++;
        end
        if (tx !== 1'b0) begin
            check({tag, " start timeout"}, {31'd0, tx}, 32'd0);
            return;
        end
        check({tag, " latency"}, w, exp_wait);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < CLK_DIV; c++) begin
                if (tx !== bits[b]) bad++;
                tick();
            end
            check($sformatf("%s bit%0d", tag, b), bad, 0);
        end
        $display("frame %s expected %02h checked", tag, exp_b);
    endtask

    task automatic end_dump(input string tag, input logic [20:0] exp_adr, input int nd);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy low"}, {31'd0, busy}, 32'd0);
        check({tag, " adr end"}, {11'd0, adr}, {11'd0, exp_adr});
        tick();
        check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
        check({tag, " done count"}, done_cnt - nd, 1);
    endtask

    task automatic check_reads(input string tag, input int nr, input int nl,
                               input logic [20:0] a0, input logic [20:0] a1);
        check({tag, " read bursts"}, rd_adr_log.size() - nr, 2);
        if (rd_adr_log.size() - nr >= 2 && rd_len_log.size() - nl >= 2) begin
            check({tag, " read adr0"}, {11'd0, rd_adr_log[nr]}, {11'd0, a0});
            check({tag, " read adr1"}, {11'd0, rd_adr_log[nr + 1]}, {11'd0, a1});
            check({tag, " read len0"}, rd_len_log[nl], RD_WAIT + 1);
            check({tag, " read len1"}, rd_len_log[nl + 1], RD_WAIT + 1);
        end
        check({tag, " adr stable in read"}, rd_adr_moved, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr, nl, nd, bad, w;

        // Reset values.
        #1 reset = 1'b1;
        #3;
        check("rst tx", {31'd0, tx}, 32'd1);
        check("rst read", {31'd0, read}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst adr", {11'd0, adr}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // Two bytes from 0x100.
        nr = rd_adr_log.size(); nl = rd_len_log.size(); nd = done_cnt;
        do_start(21'h00100, 21'd2);
        check("s1 busy", {31'd0, busy}, 32'd1);
        rx_frame("s1 b0", 8'hA5, 4);
        rx_frame("s1 b1", 8'h3C, 4);
        end_dump("s1", 21'h00102, nd);
        check_reads("s1", nr, nl, 21'h00100, 21'h00101);

        // Address wrap.
        nr = rd_adr_log.size(); nl = rd_len_log.size(); nd = done_cnt;
        do_start(21'h1FFFFF, 21'd2);
        rx_frame("s2 b0", 8'h45, 4);
        rx_frame("s2 b1", 8'h5A, 4);
        end_dump("s2", 21'h000001, nd);
        check_reads("s2", nr, nl, 21'h1FFFFF, 21'h000000);

        // Hold before the frame, then a mid-frame rise that must be ignored.
        nd = done_cnt;
        hold = 1'b1;
        do_start(21'h00200, 21'd1);
        bad = 0;
        repeat (500) begin
            if (tx !== 1'b1 || busy !== 1'b1) bad++;
            tick();
        end
        check("s3 held idle", bad, 0);
        hold = 1'b0;
        fork
            rx_frame("s3 b0", 8'h58, 1);
            begin
                repeat (300) tick();
                hold = 1'b1;
                repeat (300) tick();
                hold = 1'b0;
            end
        join
        end_dump("s3", 21'h00201, nd);

        // Empty dump.
        nr = rd_adr_log.size(); nd = done_cnt;
        do_start(21'h00040, 21'd0);
        check("s4 done", {31'd0, done}, 32'd1);
        check("s4 busy", {31'd0, busy}, 32'd0);
        tick();
        check("s4 done pulse width", {31'd0, done}, 32'd0);
        bad = 0;
        repeat (10) begin
            if (tx !== 1'b1 || busy !== 1'b0 || read !== 1'b0) bad++;
            tick();
        end
        check("s4 quiet", bad, 0);
        check("s4 no reads", rd_adr_log.size() - nr, 0);
        check("s4 done count", done_cnt - nd, 1);

        // Restart while busy is ignored.
        nr = rd_adr_log.size(); nl = rd_len_log.size(); nd = done_cnt;
        do_start(21'h00300, 21'd2);
        do_start(21'h00050, 21'd5);
        rx_frame("s5 b0", 8'h59, 3);
        rx_frame("s5 b1", 8'h58, 4);
        end_dump("s5", 21'h00302, nd);
        check_reads("s5", nr, nl, 21'h00300, 21'h00301);

        // Reset during data bit 3.
        nd = done_cnt;
        do_start(21'h00100, 21'd2);
        w = 0;
        while (tx !== 1'b0 && w < 100) begin
            tick();
            w++;
        end
        check("s6 start bit seen", {31'd0, tx}, 32'd0);
        repeat (CLK_DIV + 3 * CLK_DIV + 50) tick();
        #3 reset = 1'b1;
        #1;
        check("s6 rst tx", {31'd0, tx}, 32'd1);
        check("s6 rst busy", {31'd0, busy}, 32'd0);
        check("s6 rst adr", {11'd0, adr}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        check("s6 idle after reset", bad, 0);
        check("s6 no done", done_cnt - nd, 0);

        nr = rd_adr_log.size(); nl = rd_len_log.size(); nd = done_cnt;
        do_start(21'h00100, 21'd2);
        rx_frame("s6 b0", 8'hA5, 4);
        rx_frame("s6 b1", 8'h3C, 4);
        end_dump("s6", 21'h00102, nd);
        check_reads("s6", nr, nl, 21'h00100, 21'h00101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
